// File: rtl/shell_ctrl.sv
// Shell flight controller: launches a shell from the tank, moves it once per
// frame under integer gravity, and ends the flight on a hit, on reaching the
// ground or on leaving the screen sideways.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no shell; a shoot request loads position and velocity
// FLIGHT | shell moving; termination checked before every move
// DONE   | one-frame shell_done pulse, end_cause valid; back to IDLE
module shell_ctrl #(
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_STEP   = 2,
  parameter int GRAV_DIV = 4,
  parameter int VY_MAX   = 15,
  parameter int TANK_S   = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       shoot,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic       hit,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       shell_active,
  output logic       shell_visible,
  output logic       shell_done,
  output logic [1:0] end_cause
);

  typedef enum logic [1:0] {IDLE, FLIGHT, DONE} state_t;

  localparam int GW = (GRAV_DIV > 2) ? $clog2(GRAV_DIV) : 1;
  localparam logic [GW-1:0]      G_LAST   = GW'(GRAV_DIV - 1);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
  localparam logic signed [10:0] X_STEP_S = 11'(X_STEP);
  localparam logic signed [10:0] VY_LIM   = 11'(VY_MAX);
  localparam logic signed [10:0] VY_NEG   = -11'(VY_MAX);
  localparam logic signed [10:0] TANK_S_S = 11'(TANK_S);

  state_t state, state_nxt;
  logic signed [10:0] x, y, vx, vy;
  logic signed [10:0] x_nxt, y_nxt, vx_nxt, vy_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [1:0]    cause, cause_nxt;

  logic signed [10:0] elev, elev_clamped, vy_inc, vy_grav;

  // Launch elevation sign-extended and limited to +/-VY_MAX; gravity-bumped vy.
  always_comb begin
    elev = signed'({y_component[9], y_component});
    if (elev > VY_LIM)
      elev_clamped = VY_LIM;
    else if (elev < VY_NEG)
      elev_clamped = VY_NEG;
    else
      elev_clamped = elev;
    vy_inc  = vy + 11'sd1;
    vy_grav = (vy_inc > VY_LIM) ? VY_LIM : vy_inc;
  end

  // State register and shell kinematics; reset clears everything at once.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      vx    <= '0;
      vy    <= '0;
      gcnt  <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      vx    <= vx_nxt;
      vy    <= vy_nxt;
      gcnt  <= gcnt_nxt;
      cause <= cause_nxt;
    end
  end

  // Next-state: launch in IDLE, terminate-or-move in FLIGHT, single frame of DONE.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    vx_nxt    = vx;
    vy_nxt    = vy;
    gcnt_nxt  = gcnt;
    cause_nxt = cause;
    case (state)
      IDLE: begin
        if (shoot) begin
          x_nxt = signed'({1'b0, TankX});
          y_nxt = signed'({1'b0, TankY}) - TANK_S_S;
          case (Direction)
            2'd0:    vx_nxt = -X_STEP_S;
            2'd1:    vx_nxt = X_STEP_S;
            default: vx_nxt = '0;
          endcase
          vy_nxt    = -elev_clamped;
          gcnt_nxt  = '0;
          cause_nxt = 2'd0;
          state_nxt = FLIGHT;
        end
      end
      FLIGHT: begin
        if (hit) begin
          cause_nxt = 2'd1;
          state_nxt = DONE;
        end else if (y > Y_MAX_S) begin
          cause_nxt = 2'd2;
          state_nxt = DONE;
        end else if ((x < 11'sd0) || (x > X_MAX_S)) begin
          cause_nxt = 2'd3;
          state_nxt = DONE;
        end else begin
          x_nxt = x + vx;
          y_nxt = y + vy;
          if (gcnt == G_LAST) begin
            vy_nxt   = vy_grav;
            gcnt_nxt = '0;
          end else begin
            gcnt_nxt = gcnt + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Off-screen (negative) coordinates are reported as 0.
  assign ShellX        = x[10] ? 10'd0 : x[9:0];
  assign ShellY        = y[10] ? 10'd0 : y[9:0];
  assign shell_active  = (state == FLIGHT);
  assign shell_visible = (state == FLIGHT) && !y[10];
  assign shell_done    = (state == DONE);
  assign end_cause     = cause;

endmodule

// File: doc/shell_ctrl.md
SHELL_CTRL -- requirements
Module: shell_ctrl

Interface
- REQ-001 The module SHALL have parameter X_MAX, default 639, meaning the rightmost valid shell X.
- REQ-002 The module SHALL have parameter Y_MAX, default 479, meaning the ground line (largest valid shell Y).
- REQ-003 The module SHALL have parameter X_STEP, default 2, meaning the horizontal shell speed in pixels per frame.
- REQ-004 The module SHALL have parameter GRAV_DIV, default 4, meaning the number of frames per +1 change in vertical velocity.
- REQ-005 The module SHALL have parameter VY_MAX, default 15, meaning the vertical velocity magnitude limit.
- REQ-006 The module SHALL have parameter TANK_S, default 4, meaning the tank half-size used as the launch offset.
- REQ-007 Port frame_clk, input, 1 bit: the only clock; all state changes occur on its rising edge.
- REQ-008 Port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
- REQ-009 Port shoot, input, 1 bit: fire request from the tank controller.
- REQ-010 Ports TankX and TankY, input, 10 bits each: tank centre position.
- REQ-011 Port Direction, input, 2 bits: 0 = left, 1 = right, 2 or 3 = vertical shot.
- REQ-012 Port y_component, input, 10 bits: signed two's-complement launch elevation; a positive value fires upward.
- REQ-013 Port hit, input, 1 bit: collision indication from the collision detector.
- REQ-014 Ports ShellX and ShellY, output, 10 bits each: shell position.
- REQ-015 Port shell_active, output, 1 bit: shell is in flight.
- REQ-016 Port shell_visible, output, 1 bit: shell is in flight and 0 <= Y.
- REQ-017 Port shell_done, output, 1 bit: one-frame pulse when a flight ends.
- REQ-018 Port end_cause, output, 2 bits: 0 = none, 1 = hit, 2 = ground, 3 = side.

Function
- REQ-019 The FSM SHALL have exactly three states: IDLE, FLIGHT and DONE.
- REQ-020 In IDLE, a frame_clk edge with shoot=1 SHALL:
  - load X = TankX and Y = TankY - TANK_S;
  - set vx = -X_STEP, +X_STEP or 0 for Direction 0, 1 or 2/3 respectively;
  - set vy = -clamp(y_component, -VY_MAX, +VY_MAX);
  - clear the gravity counter and end_cause;
  - go to FLIGHT.
- REQ-021 Internal X, Y, vx and vy SHALL be 11-bit signed; all additions are signed and carry no wrap-around.
- REQ-022 In FLIGHT, each edge SHALL first evaluate termination on the current X/Y and hit, with priority hit(1) > Y > Y_MAX (ground, 2) > X < 0 or X > X_MAX (side, 3).
- REQ-023 On a termination, the module SHALL latch end_cause, hold X/Y unchanged and go to DONE.
- REQ-024 With no termination, the module SHALL update X += vx and Y += vy using the pre-edge velocities.
- REQ-025 With no termination, if gcnt == GRAV_DIV-1 then vy <= min(vy+1, VY_MAX) and gcnt <= 0; otherwise gcnt <= gcnt+1.
- REQ-026 A shell with Y < 0 SHALL stay in FLIGHT; shell_visible=0 and ShellY=0 while Y < 0.
- REQ-027 In DONE, the module SHALL assert shell_done=1 for exactly one frame, drive shell_active=0, then return to IDLE.
- REQ-028 end_cause SHALL hold its value until the next launch.
- REQ-029 shoot SHALL be ignored in FLIGHT and DONE: no reload, no queueing.
- REQ-030 hit SHALL be ignored in IDLE and DONE.
- REQ-031 ShellX/ShellY SHALL be the low 10 bits of X/Y while 0 <= value, otherwise 0.
- REQ-032 shell_active SHALL equal 1 exactly in FLIGHT.

Reset
- REQ-033 Reset=0 SHALL immediately, with no clock, force: state IDLE, X=Y=vx=vy=0, gcnt=0, ShellX=ShellY=0, shell_active=0, shell_visible=0, shell_done=0, end_cause=0.
- REQ-034 Reset=0 during FLIGHT or DONE SHALL abort the shot with no shell_done pulse.
- REQ-035 The first edge after Reset returns to 1 SHALL act as IDLE; shoot=1 on that edge SHALL launch.

Verification
- REQ-036 Launch and gravity: TankX=500, TankY=200, Direction=0, y_component=3, shoot pulse -> load (500,196) with vx=-2, vy=-3; after 4 FLIGHT edges ShellX=492, ShellY=184, vy=-2.
- REQ-037 Ground: TankY=470, Direction=2, y_component=0 -> Y sequence 466 (edges 1-4), 467, 468, 469, 470, 472, 474, 476, 478, 481 (edge 13); edge 14 gives DONE with end_cause=2; shell_done high for one frame; IDLE next.
- REQ-038 Side: TankX=636, Direction=1, y_component=0 -> X = 638, then 640; the next edge gives end_cause=3 with ShellX held at 640 & 0x3FF.
- REQ-039 Hit priority: hit=1 on the same edge as Y > Y_MAX -> end_cause=1; shoot asserted during DONE -> no relaunch, and shell_active stays 0 for the IDLE frame.
- REQ-040 Busy and reset: shoot pulses during FLIGHT -> trajectory unchanged; Reset=0 mid-FLIGHT -> all outputs 0 before the next edge; no shell_done pulse.
- REQ-041 Clamp and above-screen: y_component=10'h3E0 (-32) -> vy=+15; y_component=200 from TankY=20 -> vy=-15, shell_visible drops to 0 while Y < 0 and returns to 1 on descent.
